// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency backing-store responder for the dcache request port.
// Optional build macro: DMEM_ALIGN_CHK_EN (reject misaligned requests with a 0xBAD0BAD0 completion).
`default_nettype none

module dmem_responder #(
  parameter int LAT   = 3,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [1:0]  rstate,
  output logic        err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
`ifdef DMEM_ALIGN_CHK_EN
  localparam logic [1:0] S_ALGN = 2'd2;
`endif

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          op_q, op_nx;
  logic [31:0]   addr_q, addr_nx;
  logic [31:0]   store_q, store_nx;
  logic [31:0]   rd_hold;
  logic          complete;
  logic          req, conflict, changed;
  logic [AW-1:0] idx;
`ifdef DMEM_ALIGN_CHK_EN
  logic          bad;
`endif

  assign req      = dREN | dWEN;
  assign conflict = dREN & dWEN;
  assign changed  = (daddr != addr_q) || (dWEN != op_q);
  assign idx      = addr_q[AW+1:2];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    addr_nx  = addr_q;
    store_nx = store_q;
    dwait    = 1'b1;
    rstate   = RS_FREE;
    err      = 1'b0;
    complete = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    bad      = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (conflict) begin
          rstate = RS_ERROR;
          err    = 1'b1;
        end else if (req) begin
`ifdef DMEM_ALIGN_CHK_EN
          if (daddr[1:0] != 2'b00) begin
            rstate   = RS_ERROR;
            err      = 1'b1;
            state_nx = S_ALGN;
          end else
`endif
          begin
            rstate   = RS_BUSY;
            op_nx    = dWEN;
            addr_nx  = daddr;
            store_nx = dstore;
            cnt_nx   = LAT_M1;
            state_nx = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else if (conflict) begin
          rstate   = RS_ERROR;
          err      = 1'b1;
          state_nx = S_IDLE;
        end else if (changed) begin
          // Initiator moved to a different access: restart the latency window.
          rstate   = RS_BUSY;
          op_nx    = dWEN;
          addr_nx  = daddr;
          store_nx = dstore;
          cnt_nx   = LAT_M1;
        end else if (cnt == 4'd0) begin
          dwait    = 1'b0;
          rstate   = RS_ACCESS;
          complete = 1'b1;
          state_nx = S_IDLE;
        end else begin
          rstate   = RS_BUSY;
          cnt_nx   = cnt - 4'd1;
        end
      end

`ifdef DMEM_ALIGN_CHK_EN
      S_ALGN: begin
        dwait    = 1'b0;
        rstate   = RS_ACCESS;
        bad      = 1'b1;
        state_nx = S_IDLE;
      end
`endif

      default: state_nx = S_IDLE;
    endcase

    // Outputs read as idle while reset is held, whatever the request lines do.
    if (!nRST) begin
      dwait    = 1'b1;
      rstate   = RS_FREE;
      err      = 1'b0;
      complete = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
      bad      = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      op_q    <= 1'b0;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      rd_hold <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      op_q    <= op_nx;
      addr_q  <= addr_nx;
      store_q <= store_nx;
      if (complete && !op_q) begin
        rd_hold <= mem[idx];
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (complete && op_q) begin
      mem[idx] <= store_q;
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  assign dload = bad ? 32'hBAD0_BAD0 : ((complete && !op_q) ? mem[idx] : rd_hold);
`else
  assign dload = (complete && !op_q) ? mem[idx] : rd_hold;
`endif

endmodule

`default_nettype wire
